id_ex_stage: RTL and testbench

ID/EX pipeline register for the five-stage RV32I core, with integrated load-use hazard detection. It captures decoded operands and control from ID every cycle and presents them to EX, where they feed the operand-forwarding unit and the ALU. When the instruction in EX is a load whose destination is read by the instruction in ID, the block stalls IF/ID and inserts one bubble. It also handles flushes on a taken branch and a global freeze from the memory stage.

---
 rtl/id_ex_stage_if.sv | 58 +++++
 rtl/id_ex_stage.sv | 112 +++++++++++
 tb/tb_id_ex_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID-to-EX bundle: decoded fields and control from ID, registered copies to EX,
// plus the load-use stall request and the bubble counter.
interface id_ex_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             hold_i;
    logic             flush_i;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_memwrite;
    logic             id_memtoreg;
    logic             id_alusrc;
    logic [3:0]       id_aluop;

    logic             stall_o;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic             ex_memread;
    logic             ex_memwrite;
    logic             ex_memtoreg;
    logic             ex_alusrc;
    logic [3:0]       ex_aluop;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output hold_i, flush_i, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_memwrite,
               id_memtoreg, id_alusrc, id_aluop,
        input  stall_o, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_alusrc, ex_aluop, bubble_cnt
    );

    modport slave (
        input  hold_i, flush_i, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_memwrite,
               id_memtoreg, id_alusrc, id_aluop,
        output stall_o, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
               ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
               ex_memtoreg, ex_alusrc, ex_aluop, bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling and
// a saturating bubble counter. Define LOAD_USE_DETECT_EN to enable the load-use stall.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [XLEN-1:0]  r_imm;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;
    logic             r_valid;
    logic             r_regwrite;
    logic             r_memread;
    logic             r_memwrite;
    logic             r_memtoreg;
    logic             r_alusrc;
    logic [3:0]       r_aluop;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_lu;
    logic w_bubble;
    logic w_cnt_sat;

`ifdef LOAD_USE_DETECT_EN
    logic w_rs1_hit;
    logic w_rs2_hit;

    // rs2 only matters when it is really read: register-register ops or store data.
    assign w_rs1_hit = (r_rd == bus.id_rs1);
    assign w_rs2_hit = (r_rd == bus.id_rs2) && (!bus.id_alusrc || bus.id_memwrite);
    assign w_lu      = bus.id_valid && r_valid && r_memread && (r_rd != 5'd0)
                       && (w_rs1_hit || w_rs2_hit);
`else
    assign w_lu = 1'b0;
`endif

    assign bus.stall_o = w_lu & ~bus.hold_i & ~bus.flush_i;
    assign w_bubble    = bus.flush_i | w_lu;
    assign w_cnt_sat   = &r_bubble_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_valid      <= 1'b0;
            r_regwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_alusrc     <= 1'b0;
            r_aluop      <= '0;
            r_bubble_cnt <= '0;
        end else if (!bus.hold_i) begin
            r_pc       <= bus.id_pc;
            r_rs1_data <= bus.id_rs1_data;
            r_rs2_data <= bus.id_rs2_data;
            r_imm      <= bus.id_imm;
            r_rs1      <= bus.id_rs1;
            r_rs2      <= bus.id_rs2;
            r_rd       <= bus.id_rd;
            if (w_bubble) begin
                // Bubble kills every side effect but keeps the datapath fields flowing.
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_alusrc   <= bus.id_alusrc;
                r_aluop    <= '0;
                if (!w_cnt_sat) begin
                    r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
                end
            end else begin
                r_valid    <= bus.id_valid;
                r_regwrite <= bus.id_valid & bus.id_regwrite;
                r_memread  <= bus.id_valid & bus.id_memread;
                r_memwrite <= bus.id_valid & bus.id_memwrite;
                r_memtoreg <= bus.id_valid & bus.id_memtoreg;
                r_alusrc   <= bus.id_valid & bus.id_alusrc;
                r_aluop    <= bus.id_valid ? bus.id_aluop : 4'd0;
            end
        end
    end

    assign bus.ex_valid    = r_valid;
    assign bus.ex_pc       = r_pc;
    assign bus.ex_rs1_data = r_rs1_data;
    assign bus.ex_rs2_data = r_rs2_data;
    assign bus.ex_imm      = r_imm;
    assign bus.ex_rs1      = r_rs1;
    assign bus.ex_rs2      = r_rs2;
    assign bus.ex_rd       = r_rd;
    assign bus.ex_regwrite = r_regwrite;
    assign bus.ex_memread  = r_memread;
    assign bus.ex_memwrite = r_memwrite;
    assign bus.ex_memtoreg = r_memtoreg;
    assign bus.ex_alusrc   = r_alusrc;
    assign bus.ex_aluop    = r_aluop;
    assign bus.bubble_cnt  = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table plus hold/flush, reset-mid-stall and
// counter saturation sequences. Expectations follow LOAD_USE_DETECT_EN when defined.
module tb_id_ex_stage;
`ifdef LOAD_USE_DETECT_EN
    localparam int L = 1;
`else
    localparam int L = 0;
`endif
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt;

    always #5 clk = ~clk;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus();
    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int valid, pc, rs1, rs2, rd, rw, mr, mw, mtr, alusrc, aluop, flush;
        int e_stall, e_valid, e_pc, e_rs1, e_rd, e_rw, e_mr, e_mw, e_aluop, e_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic set_id(input int valid, input int pc, input int rs1, input int rs2,
                          input int rd, input int rw, input int mr, input int mw,
                          input int mtr, input int alusrc, input int aluop);
        bus.id_valid    = valid[0];
        bus.id_pc       = pc;
        bus.id_rs1_data = {pc[15:0], 16'h1111};
        bus.id_rs2_data = {pc[15:0], 16'h2222};
        bus.id_imm      = pc + 4;
        bus.id_rs1      = 5'(rs1);
        bus.id_rs2      = 5'(rs2);
        bus.id_rd       = 5'(rd);
        bus.id_regwrite = rw[0];
        bus.id_memread  = mr[0];
        bus.id_memwrite = mw[0];
        bus.id_memtoreg = mtr[0];
        bus.id_alusrc   = alusrc[0];
        bus.id_aluop    = 4'(aluop);
    endtask

    task automatic chk_ex(input string t, input int valid, input int pc, input int rs1,
                          input int rd, input int rw, input int mr, input int mw,
                          input int aluop, input int cnt);
        chk({t, ".ex_valid"},    32'(bus.ex_valid),    valid);
        chk({t, ".ex_pc"},       bus.ex_pc,            pc);
        chk({t, ".ex_rs1_data"}, bus.ex_rs1_data,      {pc[15:0], 16'h1111});
        chk({t, ".ex_rs1"},      32'(bus.ex_rs1),      rs1);
        chk({t, ".ex_rd"},       32'(bus.ex_rd),       rd);
        chk({t, ".ex_regwrite"}, 32'(bus.ex_regwrite), rw);
        chk({t, ".ex_memread"},  32'(bus.ex_memread),  mr);
        chk({t, ".ex_memwrite"}, 32'(bus.ex_memwrite), mw);
        chk({t, ".ex_aluop"},    32'(bus.ex_aluop),    aluop);
        chk({t, ".bubble_cnt"},  32'(bus.bubble_cnt),  cnt);
    endtask

    task automatic chk_all_zero(input string t);
        chk({t, ".ex_valid"},    32'(bus.ex_valid),    0);
        chk({t, ".ex_pc"},       bus.ex_pc,            0);
        chk({t, ".ex_rs1_data"}, bus.ex_rs1_data,      0);
        chk({t, ".ex_rs2_data"}, bus.ex_rs2_data,      0);
        chk({t, ".ex_imm"},      bus.ex_imm,           0);
        chk({t, ".ex_idx"},      32'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd}), 0);
        chk({t, ".ex_ctl"},      32'({bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite,
                                      bus.ex_memtoreg, bus.ex_alusrc, bus.ex_aluop}), 0);
        chk({t, ".bubble_cnt"},  32'(bus.bubble_cnt),  0);
        chk({t, ".stall_o"},     32'(bus.stall_o),     0);
    endtask

    initial begin
        //          valid pc      rs1 rs2 rd rw mr mw mtr as op fl | stall  valid  pc      rs1 rd rw     mr mw     op     cnt
        vecs[0]  = '{1, 'h100, 1, 2, 3, 1, 0, 0, 0, 0, 1, 0,  0,   1,     'h100, 1, 3, 1,     0, 0,     1,     0};
        vecs[1]  = '{1, 'h104, 1, 0, 5, 1, 1, 0, 1, 1, 0, 0,  0,   1,     'h104, 1, 5, 1,     1, 0,     0,     0};
        vecs[2]  = '{1, 'h108, 5, 7, 6, 1, 0, 0, 0, 0, 1, 0,  L,   1-L,   'h108, 5, 6, 1-L,   0, 0,     1-L,   L};
        vecs[3]  = '{1, 'h108, 5, 7, 6, 1, 0, 0, 0, 0, 1, 0,  0,   1,     'h108, 5, 6, 1,     0, 0,     1,     L};
        vecs[4]  = '{1, 'h10C, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0,  0,   1,     'h10C, 1, 0, 1,     1, 0,     0,     L};
        vecs[5]  = '{1, 'h110, 0, 7, 6, 1, 0, 0, 0, 0, 1, 0,  0,   1,     'h110, 0, 6, 1,     0, 0,     1,     L};
        vecs[6]  = '{1, 'h114, 1, 0, 5, 1, 1, 0, 1, 1, 0, 0,  0,   1,     'h114, 1, 5, 1,     1, 0,     0,     L};
        vecs[7]  = '{1, 'h118, 8, 5, 0, 0, 0, 1, 0, 1, 0, 0,  L,   1-L,   'h118, 8, 0, 0,     0, 1-L,   0,     2*L};
        vecs[8]  = '{1, 'h11C, 1, 0, 5, 1, 1, 0, 1, 1, 0, 0,  0,   1,     'h11C, 1, 5, 1,     1, 0,     0,     2*L};
        vecs[9]  = '{1, 'h120, 8, 5, 9, 1, 0, 0, 0, 1, 1, 0,  0,   1,     'h120, 8, 9, 1,     0, 0,     1,     2*L};
        vecs[10] = '{0, 'h124, 2, 3, 4, 1, 1, 1, 1, 0, 3, 0,  0,   0,     'h124, 2, 4, 0,     0, 0,     0,     2*L};
        vecs[11] = '{1, 'h128, 1, 0, 5, 1, 1, 0, 1, 1, 0, 0,  0,   1,     'h128, 1, 5, 1,     1, 0,     0,     2*L};
        vecs[12] = '{0, 'h12C, 5, 5, 6, 1, 0, 0, 0, 0, 1, 0,  0,   0,     'h12C, 5, 6, 0,     0, 0,     0,     2*L};
        vecs[13] = '{1, 'h130, 1, 2, 7, 1, 0, 0, 0, 0, 1, 1,  0,   0,     'h130, 1, 7, 0,     0, 0,     0,     2*L+1};
        vecs[14] = '{1, 'h134, 1, 0, 5, 1, 1, 0, 1, 1, 0, 0,  0,   1,     'h134, 1, 5, 1,     1, 0,     0,     2*L+1};
        vecs[15] = '{1, 'h138, 5, 7, 6, 1, 0, 0, 0, 0, 1, 1,  0,   0,     'h138, 5, 6, 0,     0, 0,     0,     2*L+2};

        // Reset with arbitrary ID inputs.
        bus.hold_i  = 1'b0;
        bus.flush_i = 1'b0;
        set_id(1, int'($urandom), 5, 5, 5, 1, 1, 1, 1, 1, 7);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_all_zero($sformatf("reset%0d", i));
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_id(vecs[i].valid, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rw,
                   vecs[i].mr, vecs[i].mw, vecs[i].mtr, vecs[i].alusrc, vecs[i].aluop);
            bus.flush_i = vecs[i].flush[0];
            #1;
            chk($sformatf("v%0d.stall_o", i), 32'(bus.stall_o), vecs[i].e_stall);
            @(posedge clk); #1;
            chk_ex($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_rs1, vecs[i].e_rd,
                   vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_aluop, vecs[i].e_cnt);
        end
        exp_cnt = 2*L + 2;

        // Hold masks a pending load-use stall; the stall appears once hold drops.
        @(negedge clk);
        bus.flush_i = 1'b0;
        set_id(1, 'h140, 1, 0, 5, 1, 1, 0, 1, 1, 0);
        @(posedge clk); #1;
        chk_ex("hlu.load", 1, 'h140, 1, 5, 1, 1, 0, 0, exp_cnt);
        @(negedge clk);
        set_id(1, 'h144, 5, 7, 6, 1, 0, 0, 0, 0, 1);
        bus.hold_i = 1'b1;
        #1;
        chk("hlu.stall_held", 32'(bus.stall_o), 0);
        @(posedge clk); #1;
        chk_ex("hlu.frozen", 1, 'h140, 1, 5, 1, 1, 0, 0, exp_cnt);
        @(negedge clk);
        bus.hold_i = 1'b0;
        #1;
        chk("hlu.stall_released", 32'(bus.stall_o), L);
        @(posedge clk); #1;
        exp_cnt += L;
        chk_ex("hlu.bubble", 1-L, 'h144, 5, 6, 1-L, 0, 0, 1-L, exp_cnt);
        @(posedge clk); #1;
        chk_ex("hlu.dep", 1, 'h144, 5, 6, 1, 0, 0, 1, exp_cnt);

        // Hold and flush together for three cycles: everything frozen.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_id(1, 'h300 + 4*i, 9, 9, 9, 1, 1, 1, 1, 1, 5);
            bus.hold_i  = 1'b1;
            bus.flush_i = 1'b1;
            #1;
            chk($sformatf("hf%0d.stall_o", i), 32'(bus.stall_o), 0);
            @(posedge clk); #1;
            chk_ex($sformatf("hf%0d", i), 1, 'h144, 5, 6, 1, 0, 0, 1, exp_cnt);
        end
        @(negedge clk);
        bus.hold_i = 1'b0;
        @(posedge clk); #1;
        exp_cnt += 1;
        chk_ex("hf.bubble", 0, 'h308, 9, 9, 0, 0, 0, 0, exp_cnt);
        @(negedge clk);
        bus.flush_i = 1'b0;
        set_id(0, 'h30C, 2, 2, 2, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_ex("hf.after", 0, 'h30C, 2, 2, 0, 0, 0, 0, exp_cnt);

        // Reset in the middle of a load-use stall, with hold also asserted.
        @(negedge clk);
        set_id(1, 'h150, 1, 0, 5, 1, 1, 0, 1, 1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        set_id(1, 'h154, 5, 7, 6, 1, 0, 0, 0, 0, 1);
        #1;
        chk("rst_mid.stall_before", 32'(bus.stall_o), L);
        rst         = 1'b1;
        bus.hold_i  = 1'b1;
        @(posedge clk); #1;
        rst         = 1'b0;
        bus.hold_i  = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        exp_cnt = 0;

        // Counter saturation: 20 flushes on a 4-bit counter.
        @(negedge clk);
        bus.flush_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            chk($sformatf("sat%0d.bubble_cnt", i), 32'(bus.bubble_cnt), exp_cnt);
        end
        chk("sat.final", 32'(bus.bubble_cnt), 15);
        bus.flush_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
